// File: rtl/lock_access_controller.sv
// Keypad digital-lock sequencer: frames serial code bits into attempts, compares them
// against the stored code, and drives the unlock window, closer pulse and failure lockout.
module lock_access_controller #(
    parameter int unsigned          CODE_LEN    = 4,
    parameter logic [CODE_LEN-1:0]  CODE        = CODE_LEN'(4'b1011),
    parameter int unsigned          MAX_FAIL    = 3,
    parameter int unsigned          OPEN_CYC    = 32,
    parameter int unsigned          LOCKOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       clear_entry,
    input  logic       door_closed,
    output logic       ready,
    output logic       unlocked,
    output logic       closer,
    output logic       locked_out,
    output logic [2:0] fail_cnt
);

    localparam int unsigned TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned CW   = $clog2(CODE_LEN);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_EVAL    = 3'd1,
        S_OPEN    = 3'd2,
        S_CLOSE   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] shreg_q, shreg_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [2:0]          fail_q,  fail_d;
    logic                ready_q, unlocked_q, closer_q, locked_out_q;

    // Next-state, entry framing, shared timer and failure bookkeeping
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        case (state_q)
            S_LOCKED: begin
                if (clear_entry) begin
                    shreg_d = '0;
                    cnt_d   = '0;
                end else if (bit_valid) begin
                    shreg_d = {shreg_q[CODE_LEN-2:0], bit_in};
                    if (cnt_q == CW'(CODE_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_EVAL: begin
                shreg_d = '0;
                if (shreg_q == CODE) begin
                    fail_d  = '0;
                    state_d = S_OPEN;
                end else if (fail_q + 3'd1 == 3'(MAX_FAIL)) begin
                    fail_d  = 3'(MAX_FAIL);
                    state_d = S_LOCKOUT;
                end else begin
                    fail_d  = fail_q + 3'd1;
                    state_d = S_LOCKED;
                end
            end
            S_OPEN: begin
                if (timer_q != TW'(OPEN_CYC - 1)) begin
                    timer_d = timer_q + TW'(1);
                end else if (door_closed) begin
                    state_d = S_CLOSE;
                end
            end
            S_CLOSE: begin
                state_d = S_LOCKED;
            end
            S_LOCKOUT: begin
                if (timer_q == TW'(LOCKOUT_CYC - 1)) begin
                    fail_d  = '0;
                    state_d = S_LOCKED;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_LOCKED;
            end
        endcase
        // Timer restarts from zero on every state entry
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    // State and registered Moore outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOCKED;
            shreg_q      <= '0;
            cnt_q        <= '0;
            timer_q      <= '0;
            fail_q       <= '0;
            ready_q      <= 1'b1;
            unlocked_q   <= 1'b0;
            closer_q     <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            timer_q      <= timer_d;
            fail_q       <= fail_d;
            ready_q      <= (state_d == S_LOCKED);
            unlocked_q   <= (state_d == S_OPEN);
            closer_q     <= (state_d == S_CLOSE);
            locked_out_q <= (state_d == S_LOCKOUT);
        end
    end

    assign ready      = ready_q;
    assign unlocked   = unlocked_q;
    assign closer     = closer_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed bench for lock_access_controller: unlock, held door, lockout, clear and reset.
module tb_lock_access_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_valid;
    logic       bit_in;
    logic       clear_entry;
    logic       door_closed;
    logic       ready;
    logic       unlocked;
    logic       closer;
    logic       locked_out;
    logic [2:0] fail_cnt;

    int checks = 0;
    int errors = 0;

    lock_access_controller #(
        .CODE_LEN   (4),
        .CODE       (4'b1011),
        .MAX_FAIL   (3),
        .OPEN_CYC   (8),
        .LOCKOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .clear_entry(clear_entry),
        .door_closed(door_closed),
        .ready      (ready),
        .unlocked   (unlocked),
        .closer     (closer),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_code(input logic [3:0] c);
        for (int i = 3; i >= 0; i--) send_bit(c[i]);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!ok) begin
                if (ready === 1'b1) ok = 1'b1;
                else tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_entry = 1'b0; door_closed = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ready, unlocked, closer, locked_out, fail_cnt} !== 7'b1000_000) begin
            errors++;
            $display("FAIL reset_state got=%b exp=1000000", {ready, unlocked, closer, locked_out, fail_cnt});
        end
    endtask

    task automatic test_correct_code();
        door_closed = 1'b1;
        send_code(4'b1011);
        checks++;
        if ({ready, unlocked} !== 2'b00) begin
            errors++; $display("FAIL cc_eval got=%b exp=00", {ready, unlocked});
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({unlocked, closer, fail_cnt} !== 5'b10_000) begin
                errors++; $display("FAIL cc_open cyc=%0d got=%b exp=10000", i, {unlocked, closer, fail_cnt});
            end
            tick();
        end
        checks++;
        if ({unlocked, closer, ready} !== 3'b010) begin
            errors++; $display("FAIL cc_closer got=%b exp=010", {unlocked, closer, ready});
        end
        tick();
        checks++;
        if ({ready, closer, fail_cnt} !== 5'b10_000) begin
            errors++; $display("FAIL cc_relock got=%b exp=10000", {ready, closer, fail_cnt});
        end
    endtask

    task automatic test_door_held();
        door_closed = 1'b0;
        send_code(4'b1011);
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({unlocked, closer} !== 2'b10) begin
                errors++; $display("FAIL dh_open cyc=%0d got=%b exp=10", i, {unlocked, closer});
            end
            tick();
        end
        door_closed = 1'b1;
        checks++;
        if ({unlocked, closer} !== 2'b10) begin
            errors++; $display("FAIL dh_still_open got=%b exp=10", {unlocked, closer});
        end
        tick();
        checks++;
        if ({unlocked, closer} !== 2'b01) begin
            errors++; $display("FAIL dh_closer got=%b exp=01", {unlocked, closer});
        end
        tick();
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL dh_relock got=%b exp=1", ready);
        end
    endtask

    task automatic test_lockout();
        logic [3:0] c;
        door_closed = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            send_code(4'b0000);
            tick();
            checks++;
            if ({ready, fail_cnt} !== {1'b1, 3'(k)}) begin
                errors++; $display("FAIL lo_fail%0d got=%b exp=%b", k, {ready, fail_cnt}, {1'b1, 3'(k)});
            end
        end
        send_code(4'b0000);
        tick();
        c = 4'b1011;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({locked_out, ready, unlocked, fail_cnt} !== 6'b100_011) begin
                errors++; $display("FAIL lo_active cyc=%0d got=%b exp=100011", i, {locked_out, ready, unlocked, fail_cnt});
            end
            bit_valid = (i < 4);
            bit_in    = c[3];
            c         = c << 1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        checks++;
        if ({locked_out, ready, fail_cnt} !== 5'b01_000) begin
            errors++; $display("FAIL lo_exit got=%b exp=01000", {locked_out, ready, fail_cnt});
        end
        tick();
        checks++;
        if ({ready, unlocked} !== 2'b10) begin
            errors++; $display("FAIL lo_code_ignored got=%b exp=10", {ready, unlocked});
        end
    endtask

    task automatic test_fail_then_succeed();
        bit ok;
        send_code(4'b0110);
        tick();
        checks++;
        if ({ready, fail_cnt} !== 4'b1_001) begin
            errors++; $display("FAIL fs_fail got=%b exp=1001", {ready, fail_cnt});
        end
        send_code(4'b1011);
        tick();
        checks++;
        if ({unlocked, fail_cnt} !== 4'b1_000) begin
            errors++; $display("FAIL fs_unlock got=%b exp=1000", {unlocked, fail_cnt});
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL fs_wait_ready got=timeout exp=ready");
        end
    endtask

    task automatic test_clear_entry();
        bit ok;
        logic [2:0] pre;
        pre = 3'b101;
        send_bit(1'b1);
        send_bit(1'b0);
        clear_entry = 1'b1;
        send_bit(1'b1);
        clear_entry = 1'b0;
        checks++;
        if ({ready, fail_cnt} !== 4'b1_000) begin
            errors++; $display("FAIL ce_after_clear got=%b exp=1000", {ready, fail_cnt});
        end
        for (int i = 0; i < 3; i++) begin
            send_bit(pre[2]);
            pre = pre << 1;
            checks++;
            if (ready !== 1'b1) begin
                errors++; $display("FAIL ce_no_early_eval bit=%0d got=%b exp=1", i, ready);
            end
        end
        send_bit(1'b1);
        checks++;
        if (ready !== 1'b0) begin
            errors++; $display("FAIL ce_eval got=%b exp=0", ready);
        end
        tick();
        checks++;
        if ({unlocked, fail_cnt} !== 4'b1_000) begin
            errors++; $display("FAIL ce_unlock got=%b exp=1000", {unlocked, fail_cnt});
        end
        wait_ready(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL ce_wait_ready got=timeout exp=ready");
        end
    endtask

    task automatic test_reset_open();
        door_closed = 1'b0;
        send_code(4'b1011);
        tick(); tick(); tick();
        checks++;
        if (unlocked !== 1'b1) begin
            errors++; $display("FAIL ro_pre got=%b exp=1", unlocked);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        door_closed = 1'b1;
        checks++;
        if ({ready, unlocked, closer, locked_out, fail_cnt} !== 7'b1000_000) begin
            errors++; $display("FAIL ro_reset got=%b exp=1000000", {ready, unlocked, closer, locked_out, fail_cnt});
        end
        tick();
        checks++;
        if ({ready, closer} !== 2'b10) begin
            errors++; $display("FAIL ro_no_closer got=%b exp=10", {ready, closer});
        end
    endtask

    task automatic test_reset_lockout();
        for (int k = 0; k < 3; k++) begin
            send_code(4'b0000);
            tick();
        end
        tick(); tick();
        checks++;
        if ({locked_out, fail_cnt} !== 4'b1_011) begin
            errors++; $display("FAIL rl_pre got=%b exp=1011", {locked_out, fail_cnt});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ready, unlocked, closer, locked_out, fail_cnt} !== 7'b1000_000) begin
            errors++; $display("FAIL rl_reset got=%b exp=1000000", {ready, unlocked, closer, locked_out, fail_cnt});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clear_entry = 1'b0; door_closed = 1'b1;
        test_reset();
        test_correct_code();
        test_door_held();
        test_lockout();
        test_fail_then_succeed();
        test_clear_entry();
        test_reset_open();
        test_reset_lockout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_access_controller.md
Name: lock_access_controller

Overview:
Sequencing controller for the keypad digital-lock path. It accepts a serial code-bit stream, frames it into CODE_LEN-bit attempts and compares each attempt against a stored code. It drives the unlock window and a one-cycle door-closer pulse, counts consecutive failures, and enforces a timed lockout after MAX_FAIL failures. It sits between the keypad bit serializer and the lock actuator/closer drivers.

Parameters:
CODE_LEN, 4, number of bits per attempt (2..16).
CODE, 4'b1011, stored unlock code, CODE_LEN bits wide, first-received bit = MSB.
MAX_FAIL, 3, consecutive failures that trigger lockout (1..7).
OPEN_CYC, 32, minimum cycles the lock stays unlocked (>=2).
LOCKOUT_CYC, 64, cycles spent in lockout (>=2).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
bit_valid  input  1  qualifies bit_in for one cycle.
bit_in  input  1  code bit.
clear_entry  input  1  discard partial entry; not counted as a failure.
door_closed  input  1  door sensor, 1 = closed.
ready  output  1  controller accepts bits (state LOCKED).
unlocked  output  1  lock released (state OPEN).
closer  output  1  one-cycle door-closer pulse (state CLOSE).
locked_out  output  1  lockout active (state LOCKOUT).
fail_cnt  output  3  consecutive failed attempts.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. rst sampled high -> state LOCKED, shift reg 0, bit count 0, timer 0, fail_cnt 0. Outputs after reset: ready=1, unlocked=0, closer=0, locked_out=0. rst overrides every state, including mid-entry, OPEN and LOCKOUT. No closer pulse on reset.
- All outputs are Moore: decoded from registered state; fail_cnt is a register.
- States: LOCKED, EVAL, OPEN, CLOSE, LOCKOUT.
- LOCKED:
  - bit_valid=1 -> shift bit_in in (MSB first) and increment bit count.
  - Edge that accepts the CODE_LEN-th bit -> EVAL; bit count returns to 0.
  - clear_entry=1 -> bit count and shift reg = 0. Takes priority over a simultaneous bit_valid, whose bit is dropped.
- EVAL (exactly 1 cycle, ready=0, inputs ignored):
  - Match -> OPEN, fail_cnt=0.
  - Mismatch with fail_cnt+1 == MAX_FAIL -> LOCKOUT, fail_cnt=MAX_FAIL.
  - Other mismatch -> LOCKED, fail_cnt+1.
- Latency: last bit sampled at edge k -> EVAL after k -> unlocked=1 after edge k+1.
- OPEN:
  - Timer starts at 0 on entry and increments each cycle, saturating at OPEN_CYC-1.
  - At timer==OPEN_CYC-1 with door_closed=1 -> CLOSE.
  - If door_closed=0 at that point, stay in OPEN until door_closed=1, then -> CLOSE on that edge.
  - Result: unlocked is high for at least OPEN_CYC cycles. bit_valid and clear_entry are ignored.
- CLOSE: closer=1 for exactly 1 cycle -> LOCKED; entry register is already clear.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYC cycles (timer 0..LOCKOUT_CYC-1), then -> LOCKED with fail_cnt=0.
  - Bits and clear_entry are ignored; a correct code during lockout has no effect.
- fail_cnt clears only on a successful match, on lockout exit, or on reset. clear_entry does not change it.
- Timer is shared between OPEN and LOCKOUT and cleared on every state entry. Width is clog2(max(OPEN_CYC, LOCKOUT_CYC)).

Test Plan:
Bench parameters: CODE=4'b1011, MAX_FAIL=3, OPEN_CYC=8, LOCKOUT_CYC=16.
1. Correct code: door_closed=1, bits 1,0,1,1 on consecutive cycles -> ready low 1 cycle (EVAL), then unlocked=1 for exactly 8 cycles, then closer=1 for 1 cycle, then ready=1; fail_cnt stays 0.
2. Door held open: correct code with door_closed=0 until 20 cycles after unlock -> unlocked stays 1 for those 20 cycles; closer pulses on the cycle after door_closed rises.
3. Three wrong codes: 0000 three times -> fail_cnt steps 1,2,3; locked_out=1 for exactly 16 cycles; then fail_cnt=0, ready=1; 1011 entered during lockout is ignored.
4. Fail then succeed: 0110 -> fail_cnt=1; then 1011 -> unlock and fail_cnt=0.
5. Clear entry: bits 1,0, then clear_entry together with bit_valid, then 1,0,1,1 -> unlocks; fail_cnt stays 0; no EVAL after the partial entry.
6. Reset mid-operation: rst=1 for 1 cycle during OPEN (and separately during LOCKOUT) -> next cycle unlocked=0, locked_out=0, closer=0, ready=1, fail_cnt=0.
